// File: rtl/mcb_port_pkg.sv
// Shared types for the MCB user-port responder: instruction codes, FSM states
// and the queued command record.
package mcb_port_pkg;

    localparam logic [2:0] INSTR_WR    = 3'b000;
    localparam logic [2:0] INSTR_RD    = 3'b001;
    localparam logic [2:0] INSTR_WR_AP = 3'b010;
    localparam logic [2:0] INSTR_RD_AP = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAT   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  instr;
        logic [29:0] addr;
        logic [5:0]  bl;
    } mcb_cmd_t;

    function automatic logic is_write(input logic [2:0] instr);
        return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
    endfunction

    function automatic logic is_read(input logic [2:0] instr);
        return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
    endfunction

endpackage

// File: rtl/mcb_port_responder_fifo.sv
// First-word-fall-through FIFO with registered full/empty/count and a registered
// head word, so the output is clean (zero) straight out of reset.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push, pop;

    assign push = wr_en_i && !full_q;
    assign pop  = rd_en_i && !empty_q;

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Head register: bypass the incoming word when it lands at the new head slot.
        data_d = data_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                data_d = wr_data_i;
            end else begin
                data_d = mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            data_q   <= data_d;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/mcb_port_responder.sv
// Behavioural stand-in for the MCB user port: queues commands and data in FIFOs
// and services bursts from an internal byte-writable word array.
module mcb_port_responder
    import mcb_port_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int CMD_DEPTH    = 4,
    parameter int DATA_DEPTH   = 64,
    parameter int RD_LATENCY   = 8,
    parameter int CALIB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        calib_done,
    input  logic        p0_cmd_en,
    input  logic [2:0]  p0_cmd_instr,
    input  logic [29:0] p0_cmd_byte_addr,
    input  logic [5:0]  p0_cmd_bl,
    output logic        p0_cmd_full,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_wr_data,
    input  logic [3:0]  p0_wr_mask,
    output logic        p0_wr_full,
    output logic [6:0]  p0_wr_count,
    input  logic        p0_rd_en,
    output logic [31:0] p0_rd_data,
    output logic        p0_rd_empty,
    output logic [6:0]  p0_rd_count,
    output logic [2:0]  err
);

    localparam int MEM_WORDS = 1 << ADDR_WIDTH;
    localparam int LW        = $clog2(RD_LATENCY + 1);
    localparam int KW        = $clog2(CALIB_CYCLES + 1);
    localparam int CCW       = $clog2(CMD_DEPTH + 1);

    // ---------------- FIFOs ----------------
    mcb_cmd_t         cmd_in, cmd_head;
    logic             cmd_pop, cmd_empty;
    logic [CCW-1:0]   cmd_count_unused;
    logic [29:0]      head_addr_unused;
    logic [35:0]      wr_head;
    logic             wr_pop, wr_empty;
    logic             rd_full;

    assign cmd_in.instr     = p0_cmd_instr;
    assign cmd_in.addr      = p0_cmd_byte_addr;
    assign cmd_in.bl        = p0_cmd_bl;
    assign head_addr_unused = cmd_head.addr;

    sync_fifo_fwft #(.WIDTH($bits(mcb_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (p0_cmd_en),
        .wr_data_i (cmd_in),
        .rd_en_i   (cmd_pop),
        .rd_data_o (cmd_head),
        .full_o    (p0_cmd_full),
        .empty_o   (cmd_empty),
        .count_o   (cmd_count_unused)
    );

    sync_fifo_fwft #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (p0_wr_en),
        .wr_data_i ({p0_wr_mask, p0_wr_data}),
        .rd_en_i   (wr_pop),
        .rd_data_o (wr_head),
        .full_o    (p0_wr_full),
        .empty_o   (wr_empty),
        .count_o   (p0_wr_count)
    );

    logic        rd_vld_q;
    logic [31:0] rd_word_q;

    sync_fifo_fwft #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (rd_vld_q),
        .wr_data_i (rd_word_q),
        .rd_en_i   (p0_rd_en),
        .rd_data_o (p0_rd_data),
        .full_o    (rd_full),
        .empty_o   (p0_rd_empty),
        .count_o   (p0_rd_count)
    );

    // ---------------- Calibration delay ----------------
    logic [KW-1:0] calib_cnt_q;
    logic          calib_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
        end else if (!calib_done_q) begin
            calib_cnt_q <= calib_cnt_q + KW'(1);
            if (calib_cnt_q == KW'(CALIB_CYCLES - 1)) begin
                calib_done_q <= 1'b1;
            end
        end
    end

    assign calib_done = calib_done_q;

    // ---------------- Burst FSM ----------------
    state_e                state_q, state_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [5:0]            beat_q, beat_d;
    logic [5:0]            bl_q, bl_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  is_wr_q, is_wr_d;
    logic                  mem_we, rd_issue, bad_instr;
    logic [6:0]            wr_need;

    assign wr_need = {1'b0, bl_q} + 7'd1;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        bl_d      = bl_q;
        addr_d    = addr_q;
        is_wr_d   = is_wr_q;
        cmd_pop   = 1'b0;
        wr_pop    = 1'b0;
        mem_we    = 1'b0;
        rd_issue  = 1'b0;
        bad_instr = 1'b0;
        case (state_q)
            IDLE: begin
                if (calib_done_q && !cmd_empty) begin
                    cmd_pop = 1'b1;
                    if (is_write(cmd_head.instr) || is_read(cmd_head.instr)) begin
                        state_d = LAT;
                        lat_d   = LW'(RD_LATENCY);
                        beat_d  = '0;
                        bl_d    = cmd_head.bl;
                        addr_d  = cmd_head.addr[ADDR_WIDTH+1:2];
                        is_wr_d = is_write(cmd_head.instr);
                    end else begin
                        bad_instr = 1'b1;
                    end
                end
            end
            LAT: begin
                if (lat_q == '0) begin
                    state_d = is_wr_q ? WRITE : READ;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            WRITE: begin
                // Hold until the whole burst is buffered, then stream it without stalls.
                if (!wr_empty && ((beat_q != '0) || (p0_wr_count >= wr_need))) begin
                    wr_pop = 1'b1;
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    beat_d = beat_q + 6'd1;
                    if (beat_q == bl_q) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                rd_issue = 1'b1;
                addr_d   = addr_q + ADDR_WIDTH'(1);
                beat_d   = beat_q + 6'd1;
                if (beat_q == bl_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [2:0] err_q, err_d;

    always_comb begin
        err_d = err_q | {rd_vld_q && rd_full,
                         p0_wr_en && p0_wr_full,
                         bad_instr || (p0_cmd_en && p0_cmd_full)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            beat_q   <= '0;
            bl_q     <= '0;
            addr_q   <= '0;
            is_wr_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            bl_q     <= bl_d;
            addr_q   <= addr_d;
            is_wr_q  <= is_wr_d;
            rd_vld_q <= rd_issue;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

    // ---------------- Word array (not reset) ----------------
    logic [3:0][7:0] mem [0:MEM_WORDS-1];
    logic [3:0]      mem_be;

    assign mem_be = ~wr_head[35:32];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[addr_q][b] <= wr_head[8*b +: 8];
                end
            end
        end
        rd_word_q <= mem[addr_q];
    end

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed bench for mcb_port_responder: calibration, bursts, masks, wrap,
// latency, flow control and sticky error flags.
module tb_mcb_port_responder;
    import mcb_port_pkg::*;

    localparam int RD_LATENCY   = 8;
    localparam int CALIB_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [29:0] p0_cmd_byte_addr;
    logic [5:0]  p0_cmd_bl;
    logic        p0_cmd_full;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic [3:0]  p0_wr_mask;
    logic        p0_wr_full;
    logic [6:0]  p0_wr_count;
    logic        p0_rd_en;
    logic [31:0] p0_rd_data;
    logic        p0_rd_empty;
    logic [6:0]  p0_rd_count;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_buf [0:127];
    int rd_n;

    always #5 clk = ~clk;

    mcb_port_responder #(
        .ADDR_WIDTH(10), .CMD_DEPTH(4), .DATA_DEPTH(64),
        .RD_LATENCY(RD_LATENCY), .CALIB_CYCLES(CALIB_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_full(p0_cmd_full),
        .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
        .p0_wr_full(p0_wr_full), .p0_wr_count(p0_wr_count),
        .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty),
        .p0_rd_count(p0_rd_count), .err(err)
    );

    task automatic apply_reset();
        reset = 1'b1;
        p0_cmd_en = 0; p0_cmd_instr = 0; p0_cmd_byte_addr = 0; p0_cmd_bl = 0;
        p0_wr_en = 0; p0_wr_data = 0; p0_wr_mask = 0; p0_rd_en = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [29:0] baddr, input logic [5:0] bl);
        p0_cmd_en = 1'b1; p0_cmd_instr = instr; p0_cmd_byte_addr = baddr; p0_cmd_bl = bl;
        @(negedge clk);
        p0_cmd_en = 1'b0;
        $display("cmd   instr=%b byte_addr=0x%0h bl=%0d", instr, baddr, bl);
    endtask

    task automatic push_words(input logic [31:0] base, input int n, input logic [3:0] mask);
        for (int i = 0; i < n; i++) begin
            p0_wr_en = 1'b1; p0_wr_data = base + i; p0_wr_mask = mask;
            @(negedge clk);
        end
        p0_wr_en = 1'b0;
        $display("wdata %0d words from 0x%08h mask=%b", n, base, mask);
    endtask

    task automatic collect(input int n, input int budget);
        rd_n = 0;
        for (int cyc = 0; cyc < budget && rd_n < n; cyc++) begin
            if (!p0_rd_empty) begin
                rd_buf[rd_n] = p0_rd_data;
                rd_n++;
                p0_rd_en = 1'b1;
            end else begin
                p0_rd_en = 1'b0;
            end
            @(negedge clk);
        end
        p0_rd_en = 1'b0;
        $display("rdata collected %0d of %0d words", rd_n, n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        p0_cmd_en = 0; p0_wr_en = 0; p0_rd_en = 0;
        @(negedge clk);
        checks++;
        if ({calib_done, p0_cmd_full, p0_wr_full, p0_wr_count, p0_rd_empty, p0_rd_count, p0_rd_data, err}
            !== {1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd0, 32'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_values: calib=%b cfull=%b wfull=%b wcnt=%0d empty=%b rcnt=%0d data=%h err=%b",
                     calib_done, p0_cmd_full, p0_wr_full, p0_wr_count, p0_rd_empty, p0_rd_count, p0_rd_data, err);
        end
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == CALIB_CYCLES - 1) begin
                checks++;
                if (calib_done !== 1'b0) begin
                    errors++;
                    $display("FAIL calib_early: cycle %0d calib_done=%b expected 0", k, calib_done);
                end
            end
            if (k == CALIB_CYCLES) begin
                checks++;
                if (calib_done !== 1'b1) begin
                    errors++;
                    $display("FAIL calib_rise: cycle %0d calib_done=%b expected 1", k, calib_done);
                end
            end
            checks++;
            if (p0_rd_empty !== 1'b1 || err !== 3'b000) begin
                errors++;
                $display("FAIL idle_state: cycle %0d rd_empty=%b err=%b expected 1/000", k, p0_rd_empty, err);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_burst();
        push_words(32'h1000, 32, 4'b0000);
        push_cmd(INSTR_WR, 30'h80, 6'd31);
        push_cmd(INSTR_RD, 30'h80, 6'd31);
        collect(32, 400);
        checks++;
        if (rd_n !== 32) begin
            errors++;
            $display("FAIL burst_count: got %0d words expected 32", rd_n);
        end
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h1000 + i) begin
                errors++;
                $display("FAIL burst_data[%0d]: got %h expected %h", i, rd_buf[i], 32'h1000 + i);
            end
        end
        checks++;
        if (err !== 3'b000) begin
            errors++;
            $display("FAIL burst_err: err=%b expected 000", err);
        end
        $display("test_burst done");
    endtask

    task automatic test_mask();
        push_words(32'hAABBCCDD, 1, 4'b0000);
        push_words(32'h11223344, 1, 4'b0101);
        push_cmd(INSTR_WR, 30'h200, 6'd0);
        push_cmd(INSTR_WR_AP, 30'h200, 6'd0);
        push_cmd(INSTR_RD, 30'h200, 6'd0);
        collect(1, 200);
        checks++;
        if (rd_n !== 1 || rd_buf[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL mask_merge: n=%0d got %h expected 11bb33dd", rd_n, rd_buf[0]);
        end
        $display("test_mask done");
    endtask

    task automatic test_wrap();
        push_words(32'hC0DE0000, 4, 4'b0000);
        push_cmd(INSTR_WR, 30'hFF8, 6'd3);
        push_cmd(INSTR_RD_AP, 30'hFFB, 6'd3);
        collect(4, 200);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_n !== 4 || rd_buf[i] !== 32'hC0DE0000 + i) begin
                errors++;
                $display("FAIL wrap_read[%0d]: n=%0d got %h expected %h", i, rd_n, rd_buf[i], 32'hC0DE0000 + i);
            end
        end
        push_cmd(INSTR_RD, 30'h0, 6'd1);
        collect(2, 200);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd_n !== 2 || rd_buf[i] !== 32'hC0DE0002 + i) begin
                errors++;
                $display("FAIL wrap_low[%0d]: n=%0d got %h expected %h", i, rd_n, rd_buf[i], 32'hC0DE0002 + i);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_latency();
        int k;
        p0_cmd_en = 1'b1; p0_cmd_instr = INSTR_RD; p0_cmd_byte_addr = 30'h80; p0_cmd_bl = 6'd0;
        @(negedge clk);
        p0_cmd_en = 1'b0;
        k = 1;
        while (p0_rd_empty && k < 60) begin
            @(negedge clk);
            k++;
        end
        // one edge for the push, one for the pop, then RD_LATENCY+3 to the FIFO output
        checks++;
        if (k !== RD_LATENCY + 5) begin
            errors++;
            $display("FAIL read_latency: empty fell at sample %0d expected %0d", k, RD_LATENCY + 5);
        end
        checks++;
        if (p0_rd_data !== 32'h1000) begin
            errors++;
            $display("FAIL latency_data: got %h expected 00001000", p0_rd_data);
        end
        p0_rd_en = 1'b1;
        @(negedge clk);
        p0_rd_en = 1'b0;
        checks++;
        if (p0_rd_empty !== 1'b1 || p0_rd_count !== 7'd0) begin
            errors++;
            $display("FAIL latency_drain: empty=%b count=%0d expected 1/0", p0_rd_empty, p0_rd_count);
        end
        $display("test_latency done, first word at sample %0d", k);
    endtask

    task automatic test_partial_write();
        push_words(32'h2000, 10, 4'b0000);
        push_cmd(INSTR_WR, 30'h400, 6'd31);
        repeat (40) @(negedge clk);
        checks++;
        if (p0_wr_count !== 7'd10) begin
            errors++;
            $display("FAIL partial_hold: wr_count=%0d expected 10", p0_wr_count);
        end
        push_words(32'h200A, 22, 4'b0000);
        push_cmd(INSTR_RD, 30'h400, 6'd31);
        collect(32, 400);
        checks++;
        if (rd_n !== 32 || p0_wr_count !== 7'd0) begin
            errors++;
            $display("FAIL partial_done: words=%0d wr_count=%0d expected 32/0", rd_n, p0_wr_count);
        end
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h2000 + i) begin
                errors++;
                $display("FAIL partial_data[%0d]: got %h expected %h", i, rd_buf[i], 32'h2000 + i);
            end
        end
        $display("test_partial_write done");
    endtask

    task automatic test_rd_overflow();
        int k;
        push_cmd(INSTR_RD, 30'h80, 6'd31);
        push_cmd(INSTR_RD, 30'h80, 6'd31);
        push_cmd(INSTR_RD, 30'h80, 6'd31);
        k = 0;
        while (p0_rd_count !== 7'd64 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (p0_rd_count !== 7'd64 || err !== 3'b000) begin
            errors++;
            $display("FAIL rd_fill: count=%0d err=%b expected 64/000", p0_rd_count, err);
        end
        repeat (150) @(negedge clk);
        checks++;
        if (p0_rd_count !== 7'd64 || err !== 3'b100 || p0_rd_data !== 32'h1000) begin
            errors++;
            $display("FAIL rd_overflow: count=%0d err=%b head=%h expected 64/100/00001000",
                     p0_rd_count, err, p0_rd_data);
        end
        $display("test_rd_overflow done");
    endtask

    task automatic test_flow_errors();
        apply_reset();
        for (int i = 0; i < 4; i++) push_cmd(INSTR_RD, 30'h80, 6'd0);
        checks++;
        if (p0_cmd_full !== 1'b1 || err !== 3'b000) begin
            errors++;
            $display("FAIL cmd_full: full=%b err=%b expected 1/000", p0_cmd_full, err);
        end
        push_cmd(INSTR_RD, 30'h80, 6'd0);
        checks++;
        if (err !== 3'b001) begin
            errors++;
            $display("FAIL cmd_overflow: err=%b expected 001", err);
        end
        push_words(32'h3000, 64, 4'b0000);
        checks++;
        if (p0_wr_full !== 1'b1 || p0_wr_count !== 7'd64 || err !== 3'b001) begin
            errors++;
            $display("FAIL wr_full: full=%b count=%0d err=%b expected 1/64/001", p0_wr_full, p0_wr_count, err);
        end
        push_words(32'h3040, 1, 4'b0000);
        checks++;
        if (err !== 3'b011 || p0_wr_count !== 7'd64) begin
            errors++;
            $display("FAIL wr_overflow: err=%b count=%0d expected 011/64", err, p0_wr_count);
        end
        collect(4, 300);
        checks++;
        if (rd_n !== 4 || rd_buf[0] !== 32'h1000 || rd_buf[3] !== 32'h1000) begin
            errors++;
            $display("FAIL array_kept: n=%0d w0=%h w3=%h expected 4/00001000", rd_n, rd_buf[0], rd_buf[3]);
        end
        $display("test_flow_errors done");
    endtask

    task automatic test_bad_instr();
        apply_reset();
        repeat (CALIB_CYCLES + 2) @(negedge clk);
        push_cmd(3'b101, 30'h0, 6'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 3'b001 || p0_rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL bad_instr: err=%b empty=%b expected 001/1", err, p0_rd_empty);
        end
        push_cmd(INSTR_RD, 30'h200, 6'd0);
        collect(1, 200);
        checks++;
        if (rd_n !== 1 || rd_buf[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL after_bad_instr: n=%0d got %h expected 11bb33dd", rd_n, rd_buf[0]);
        end
        $display("test_bad_instr done");
    endtask

    initial begin
        test_reset();
        test_burst();
        test_mask();
        test_wrap();
        test_latency();
        test_partial_write();
        test_rd_overflow();
        test_flow_errors();
        test_bad_instr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
